// File: rtl/deser_queue_pkg.sv
// Shared widths and types for the serial capture subsystem.
package deser_queue_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned LEN_W  = 4;

    typedef logic [DATA_W-1:0] byte_t;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte queue: push at tail, pop into a held output register at head.
module byte_fifo
    import deser_queue_pkg::*;
#(
    parameter int unsigned N_ENTRIES = DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic [LEN_W-1:0]  count,
    output logic              full
);

    localparam int unsigned PTR_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

    byte_t            mem [N_ENTRIES];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             do_push;
    logic             do_pop;

    // Both decisions use the pre-edge count, so a push and a pop in the
    // same cycle leave the occupancy unchanged and the pop sees the old head.
    assign full    = (count == LEN_W'(N_ENTRIES));
    assign do_push = push && !full;
    assign do_pop  = pop && (count != '0);

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[tail] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            data_out <= '0;
        end else begin
            if (do_push) begin
                tail <= (tail == PTR_W'(N_ENTRIES - 1)) ? '0 : tail + 1'b1;
            end
            if (do_pop) begin
                data_out <= mem[head];
                head     <= (head == PTR_W'(N_ENTRIES - 1)) ? '0 : head + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/deser_queue_top.sv
// MSB-first serial-to-byte deserializer with strobe edge detection,
// feeding an 8-entry byte queue drained by dequeue pulses.
module deser_queue_top
    import deser_queue_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              data_in,
    input  logic              write_in,
    output logic              status_out,
    input  logic              dequeue_in,
    output logic [DATA_W-1:0] data_out,
    output logic [LEN_W-1:0]  len_out
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    logic              write_prev;
    logic              deq_prev;
    logic              write_ev;
    logic              deq_ev;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] shift_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic              pending;
    logic              push;
    logic              full;

    // A strobe held high for many cycles yields one event on its rising edge.
    assign write_ev   = write_in && !write_prev;
    assign deq_ev     = dequeue_in && !deq_prev;
    assign shift_next = {shift_q[DATA_W-2:0], data_in};
    assign push       = pending && !full;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            write_prev <= 1'b0;
            deq_prev   <= 1'b0;
        end else begin
            write_prev <= write_in;
            deq_prev   <= dequeue_in;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            word_q  <= '0;
            bit_cnt <= '0;
            pending <= 1'b0;
        end else begin
            if (write_ev && status_out) begin
                shift_q <= shift_next;
                if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                    bit_cnt <= '0;
                    word_q  <= shift_next;
                    pending <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (push) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            status_out <= 1'b0;
        end else begin
            status_out <= !pending && !full;
        end
    end

    byte_fifo #(
        .N_ENTRIES (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (word_q),
        .pop       (deq_ev),
        .data_out  (data_out),
        .count     (len_out),
        .full      (full)
    );

endmodule

// File: tb/tb_deser_queue_top.sv
// Directed bench for deser_queue_top with hand-computed expectations.
module tb_deser_queue_top;
    import deser_queue_pkg::*;

    logic              clock = 1'b0;
    logic              reset;
    logic              data_in;
    logic              write_in;
    logic              status_out;
    logic              dequeue_in;
    logic [DATA_W-1:0] data_out;
    logic [LEN_W-1:0]  len_out;

    int errors = 0;
    int checks = 0;

    logic [31:0] drain_exp [8] = '{32'h83, 32'h10, 32'h11, 32'h12,
                                   32'h13, 32'h14, 32'h15, 32'h3C};

    deser_queue_top dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .write_in   (write_in),
        .status_out (status_out),
        .dequeue_in (dequeue_in),
        .data_out   (data_out),
        .len_out    (len_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One bit: strobe high 10 cycles, low 10 cycles. On a word's last bit,
    // optionally check the status dip and raise dequeue so it lands on the push edge.
    task automatic send_bit(input logic v, input logic chk, input logic pop);
        data_in  = v;
        write_in = 1'b1;
        @(posedge clock); #1;
        if (pop) dequeue_in = 1'b1;
        @(posedge clock); #1;
        if (chk) check("status_dip", 32'(status_out), 32'd0);
        @(posedge clock); #1;
        if (chk) check("status_back", 32'(status_out), 32'd1);
        repeat (7) @(posedge clock);
        #1;
        write_in   = 1'b0;
        dequeue_in = 1'b0;
        repeat (10) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic chk, input logic pop);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i], chk && (i == 0), pop && (i == 0));
        end
    endtask

    task automatic pop_pulse(input int hold);
        dequeue_in = 1'b1;
        repeat (hold) @(posedge clock);
        #1;
        dequeue_in = 1'b0;
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        data_in    = 1'b0;
        write_in   = 1'b0;
        dequeue_in = 1'b0;
        #2;
        check("rst_status", 32'(status_out), 32'd0);
        check("rst_data", 32'(data_out), 32'h00);
        check("rst_len", 32'(len_out), 32'd0);
        repeat (3) @(posedge clock);
        #1;
        check("rst_hold_status", 32'(status_out), 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        check("release_status", 32'(status_out), 32'd1);
        check("release_len", 32'(len_out), 32'd0);

        // First byte 0x80
        send_byte(8'h80, 1'b1, 1'b0);
        check("first_len", 32'(len_out), 32'd1);
        pop_pulse(5);
        check("first_pop_data", 32'(data_out), 32'h80);
        check("first_pop_len", 32'(len_out), 32'd0);

        // Four bytes, then a long dequeue pulse pops exactly one
        for (int k = 0; k < 4; k++) send_byte(8'(8'h80 + k), 1'b1, 1'b0);
        check("four_len", 32'(len_out), 32'd4);
        pop_pulse(200);
        check("long_pop_data", 32'(data_out), 32'h80);
        check("long_pop_len", 32'(len_out), 32'd3);
        pop_pulse(5);
        check("second_pop_data", 32'(data_out), 32'h81);
        check("second_pop_len", 32'(len_out), 32'd2);

        // Fill to 8 entries; further bits are dropped while full
        for (int k = 0; k < 6; k++) send_byte(8'(8'h10 + k), 1'b0, 1'b0);
        check("full_len", 32'(len_out), 32'd8);
        check("full_status", 32'(status_out), 32'd0);
        send_byte(8'hFF, 1'b0, 1'b0);
        check("ignored_len", 32'(len_out), 32'd8);
        check("ignored_status", 32'(status_out), 32'd0);
        pop_pulse(5);
        check("full_pop_data", 32'(data_out), 32'h82);
        check("full_pop_len", 32'(len_out), 32'd7);
        check("full_pop_status", 32'(status_out), 32'd1);
        send_byte(8'h3C, 1'b0, 1'b0);
        check("refill_len", 32'(len_out), 32'd8);
        for (int k = 0; k < 8; k++) begin
            pop_pulse(3);
            check("drain_data", 32'(data_out), drain_exp[k]);
        end
        check("drain_len", 32'(len_out), 32'd0);

        // Pop on empty leaves outputs untouched
        pop_pulse(5);
        check("empty_pop_data", 32'(data_out), 32'h3C);
        check("empty_pop_len", 32'(len_out), 32'd0);

        // Push and pop on the same edge, across pointer wrap
        send_byte(8'hA0, 1'b1, 1'b0);
        send_byte(8'hA1, 1'b1, 1'b0);
        check("pair_prefill_len", 32'(len_out), 32'd2);
        for (int k = 0; k < 12; k++) begin
            send_byte(8'(8'hB0 + k), 1'b0, 1'b1);
            check("pair_len", 32'(len_out), 32'd2);
            if (k == 0)      check("pair_data", 32'(data_out), 32'hA0);
            else if (k == 1) check("pair_data", 32'(data_out), 32'hA1);
            else             check("pair_data", 32'(data_out), 32'(8'hB0 + k - 2));
        end
        pop_pulse(3);
        check("pair_tail0", 32'(data_out), 32'hBA);
        pop_pulse(3);
        check("pair_tail1", 32'(data_out), 32'hBB);
        check("pair_drain_len", 32'(len_out), 32'd0);

        // Reset mid-word discards queue and partial bits
        send_byte(8'h55, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) send_bit(1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check("midrst_len", 32'(len_out), 32'd0);
        check("midrst_status", 32'(status_out), 32'd0);
        check("midrst_data", 32'(data_out), 32'h00);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_release_status", 32'(status_out), 32'd0);
        @(posedge clock); #1;
        check("midrst_ready", 32'(status_out), 32'd1);
        send_byte(8'h0F, 1'b1, 1'b0);
        check("post_rst_len", 32'(len_out), 32'd1);
        pop_pulse(3);
        check("post_rst_data", 32'(data_out), 32'h0F);
        check("post_rst_final_len", 32'(len_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
